// File: rtl/mixer_tune_ctrl.sv
// Retuning controller for the quadrature mixer NCO.
// Frequency-change requests arrive over a valid/ready handshake. Each one is
// applied as a muted jump or as a phase-continuous ramp. A settle period then
// covers the mixer and decimator pipeline before done pulses.
//
// state  | meaning
// -------+----------------------------------------------------------------
// IDLE   | phase_inc stable, tune_ready high, waiting for a request
// RAMP   | phase_inc stepping toward the latched target, mixer unmuted
// SETTLE | final phase_inc applied, counting out pipeline latency
module mixer_tune_ctrl #(
  parameter int                     PHASE_WIDTH   = 32,
  parameter logic [PHASE_WIDTH-1:0] RAMP_STEP     = 'h0010_0000,
  parameter int                     SETTLE_CYCLES = 16,
  parameter logic [PHASE_WIDTH-1:0] RESET_INC     = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   tune_valid,
  output logic                   tune_ready,
  input  logic [PHASE_WIDTH-1:0] tune_word,
  input  logic                   tune_ramp,
  input  logic                   abort,
  output logic [PHASE_WIDTH-1:0] phase_inc,
  output logic                   mute,
  output logic                   busy,
  output logic                   done
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RAMP,
    S_SETTLE
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [PHASE_WIDTH-1:0] phase_q, phase_d;
  logic [PHASE_WIDTH-1:0] target_q, target_d;
  logic                   mute_q, mute_d;
  logic                   done_q, done_d;
  logic                   ready_q, ready_d;

  logic [PHASE_WIDTH-1:0] tgt;
  logic [PHASE_WIDTH:0]   diff;
  logic [PHASE_WIDTH:0]   mag;
  logic                   step_down;
  logic                   far;
  logic                   equal;
  logic [PHASE_WIDTH-1:0] step_val;

  // Distance to target, one bit wider so it cannot overflow at either end of
  // the range. In IDLE the request word is compared directly, because the
  // target is only latched at the handshake.
  always_comb begin
    tgt       = (state_q == S_IDLE) ? tune_word : target_q;
    diff      = {1'b0, tgt} - {1'b0, phase_q};
    step_down = diff[PHASE_WIDTH];
    mag       = step_down ? (~diff + 1'b1) : diff;
    far       = (mag > {1'b0, RAMP_STEP});
    equal     = (mag == '0);
    // Applied only when far, so the step can neither overshoot nor wrap.
    step_val  = step_down ? (phase_q - RAMP_STEP) : (phase_q + RAMP_STEP);
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    phase_d  = phase_q;
    target_d = target_q;
    mute_d   = mute_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        mute_d = 1'b0;
        if (tune_valid) begin
          target_d = tune_word;
          if (equal) begin
            done_d = 1'b1;
          end else if (!tune_ramp || !far) begin
            phase_d = tune_word;
            state_d = S_SETTLE;
            cnt_d   = CNT_INIT;
            mute_d  = !tune_ramp;
          end else begin
            state_d = S_RAMP;
          end
        end
      end
      S_RAMP: begin
        mute_d = 1'b0;
        if (abort) begin
          state_d = S_SETTLE;
          cnt_d   = CNT_INIT;
        end else if (far) begin
          phase_d = step_val;
        end else begin
          phase_d = target_q;
          state_d = S_SETTLE;
          cnt_d   = CNT_INIT;
        end
      end
      S_SETTLE: begin
        if (cnt_q <= CNT_ONE) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          mute_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = S_SETTLE;
        cnt_d   = CNT_INIT;
        mute_d  = 1'b1;
      end
    endcase
    ready_d = (state_d == S_IDLE);
  end

  // State and output registers. Reset enters a jump-type settle so the
  // downstream pipeline is flushed before the first request is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_SETTLE;
      cnt_q    <= CNT_INIT;
      phase_q  <= RESET_INC;
      target_q <= RESET_INC;
      mute_q   <= 1'b1;
      done_q   <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      target_q <= target_d;
      mute_q   <= mute_d;
      done_q   <= done_d;
      ready_q  <= ready_d;
    end
  end

  assign tune_ready = ready_q;
  assign busy       = !ready_q;
  assign phase_inc  = phase_q;
  assign mute       = mute_q;
  assign done       = done_q;

endmodule

// File: tb/tb_mixer_tune_ctrl.sv
// Scoreboard bench for mixer_tune_ctrl with directed retune scenarios.
module tb_mixer_tune_ctrl;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         tune_valid = 1'b0;
  logic         tune_ready;
  logic [W-1:0] tune_word = '0;
  logic         tune_ramp = 1'b0;
  logic         abort = 1'b0;
  logic [W-1:0] phase_inc;
  logic         mute;
  logic         busy;
  logic         done;

  always #5 clk = ~clk;

  mixer_tune_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tune_valid (tune_valid),
    .tune_ready (tune_ready),
    .tune_word  (tune_word),
    .tune_ramp  (tune_ramp),
    .abort      (abort),
    .phase_inc  (phase_inc),
    .mute       (mute),
    .busy       (busy),
    .done       (done)
  );

  typedef struct {
    int           cyc;
    logic [W-1:0] ph;
    logic         mute;
    logic         ready;
    string        name;
  } chk_t;

  chk_t chk_q[$];
  int   done_exp_q[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always @(posedge clk) cyc++;

  task automatic expect_at(input int c, input logic [W-1:0] ph, input logic m,
                           input logic r, input string nm);
    chk_t e;
    e.cyc = c; e.ph = ph; e.mute = m; e.ready = r; e.name = nm;
    chk_q.push_back(e);
  endtask

  task automatic expect_span(input int c0, input int c1, input logic [W-1:0] ph,
                             input logic m, input logic r, input string nm);
    for (int c = c0; c <= c1; c++) expect_at(c, ph, m, r, nm);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk); #1;
    end
  endtask

  // Present a request and hold it until the handshake; t is the accept cycle.
  task automatic issue(input logic [W-1:0] w, input logic r, input logic ab,
                       output int t);
    tune_word = w; tune_ramp = r; abort = ab; tune_valid = 1'b1; t = -1;
    for (int n = 0; n < 200; n++) begin
      if (tune_ready === 1'b1) begin
        t = cyc;
        break;
      end
      @(posedge clk); #1;
    end
    if (t < 0) begin
      total++; bad++;
      $display("FAIL handshake_timeout word=%h: tune_ready never seen, want 1", w);
    end else begin
      @(posedge clk); #1;
    end
    tune_valid = 1'b0; abort = 1'b0;
  endtask

  // Monitor: compares scheduled per-cycle expectations and every done pulse.
  always @(negedge clk) begin
    int i;
    int hit;
    i = 0;
    while (i < chk_q.size()) begin
      if (chk_q[i].cyc == cyc) begin
        total++;
        if (phase_inc !== chk_q[i].ph || mute !== chk_q[i].mute ||
            tune_ready !== chk_q[i].ready || busy !== !chk_q[i].ready) begin
          bad++;
          $display("FAIL %s cyc=%0d: got phase_inc=%h mute=%b ready=%b busy=%b, want phase_inc=%h mute=%b ready=%b busy=%b",
                   chk_q[i].name, cyc, phase_inc, mute, tune_ready, busy,
                   chk_q[i].ph, chk_q[i].mute, chk_q[i].ready, !chk_q[i].ready);
        end
        chk_q.delete(i);
      end else if (chk_q[i].cyc < cyc) begin
        total++; bad++;
        $display("FAIL %s cyc=%0d: check not sampled, want sample at cyc=%0d",
                 chk_q[i].name, cyc, chk_q[i].cyc);
        chk_q.delete(i);
      end else begin
        i++;
      end
    end
    hit = -1;
    foreach (done_exp_q[k]) if (done_exp_q[k] == cyc) hit = k;
    if (done === 1'b1) begin
      total++;
      if (hit < 0) begin
        bad++;
        $display("FAIL done_unexpected cyc=%0d: got done=1, want 0", cyc);
      end else begin
        done_exp_q.delete(hit);
      end
    end else if (hit >= 0) begin
      total++; bad++;
      $display("FAIL done_missing cyc=%0d: got done=%b, want 1", cyc, done);
      done_exp_q.delete(hit);
    end
  end

  initial begin
    int t;
    int t2;
    int r;

    // Reset held, then released: 16 muted settle cycles, done on the 17th.
    repeat (3) @(posedge clk);
    #1;
    expect_at(cyc, 32'h0, 1'b1, 1'b0, "reset_hold");
    @(posedge clk); #1;
    rst_n = 1'b1; r = cyc;
    expect_span(r, r + 15, 32'h0, 1'b1, 1'b0, "reset_settle");
    expect_at(r + 16, 32'h0, 1'b0, 1'b1, "reset_done");
    done_exp_q.push_back(r + 16);
    wait_cyc(r + 16);

    // Ramp up 0 -> 0x0035_0000.
    issue(32'h0035_0000, 1'b1, 1'b0, t);
    expect_at(t + 1, 32'h0000_0000, 1'b0, 1'b0, "ramp_up_enter");
    expect_at(t + 2, 32'h0010_0000, 1'b0, 1'b0, "ramp_up_s1");
    expect_at(t + 3, 32'h0020_0000, 1'b0, 1'b0, "ramp_up_s2");
    expect_at(t + 4, 32'h0030_0000, 1'b0, 1'b0, "ramp_up_s3");
    expect_span(t + 5, t + 20, 32'h0035_0000, 1'b0, 1'b0, "ramp_up_settle");
    expect_at(t + 21, 32'h0035_0000, 1'b0, 1'b1, "ramp_up_done");
    done_exp_q.push_back(t + 21);
    wait_cyc(t + 21);

    // Ramp down toward 1, aborted after two steps.
    issue(32'h0000_0001, 1'b1, 1'b0, t);
    expect_at(t + 1, 32'h0035_0000, 1'b0, 1'b0, "ramp_dn_enter");
    expect_at(t + 2, 32'h0025_0000, 1'b0, 1'b0, "ramp_dn_s1");
    expect_at(t + 3, 32'h0015_0000, 1'b0, 1'b0, "ramp_dn_s2");
    expect_span(t + 4, t + 19, 32'h0015_0000, 1'b0, 1'b0, "ramp_dn_abort_settle");
    expect_at(t + 20, 32'h0015_0000, 1'b0, 1'b1, "ramp_dn_done");
    done_exp_q.push_back(t + 20);
    wait_cyc(t + 3);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    wait_cyc(t + 20);

    // Request equal to current phase_inc: immediate done, no settle.
    issue(32'h0015_0000, 1'b0, 1'b0, t);
    expect_at(t + 1, 32'h0015_0000, 1'b0, 1'b1, "equal_word");
    done_exp_q.push_back(t + 1);
    wait_cyc(t + 2);

    // Jump with abort asserted alongside the request (abort ignored in IDLE).
    issue(32'h0800_0000, 1'b0, 1'b1, t);
    expect_span(t + 1, t + 16, 32'h0800_0000, 1'b1, 1'b0, "jump_settle");
    expect_at(t + 17, 32'h0800_0000, 1'b0, 1'b1, "jump_done");
    done_exp_q.push_back(t + 17);
    wait_cyc(t + 17);

    // Ramp request exactly RAMP_STEP away: applied at once, unmuted settle.
    issue(32'h0810_0000, 1'b1, 1'b0, t);
    expect_span(t + 1, t + 16, 32'h0810_0000, 1'b0, 1'b0, "ramp_eq_step_settle");
    expect_at(t + 17, 32'h0810_0000, 1'b0, 1'b1, "ramp_eq_step_done");
    done_exp_q.push_back(t + 17);
    wait_cyc(t + 17);

    // Jump near the top of the range, then ramp down without wrapping.
    issue(32'hFFFF_FFF0, 1'b0, 1'b0, t);
    expect_span(t + 1, t + 16, 32'hFFFF_FFF0, 1'b1, 1'b0, "top_jump_settle");
    done_exp_q.push_back(t + 17);
    wait_cyc(t + 17);
    issue(32'h0000_0010, 1'b1, 1'b0, t);
    expect_at(t + 1, 32'hFFFF_FFF0, 1'b0, 1'b0, "top_ramp_enter");
    expect_at(t + 2, 32'hFFEF_FFF0, 1'b0, 1'b0, "top_ramp_s1");
    expect_at(t + 3, 32'hFFDF_FFF0, 1'b0, 1'b0, "top_ramp_s2");
    expect_span(t + 4, t + 19, 32'hFFDF_FFF0, 1'b0, 1'b0, "top_ramp_abort_settle");
    done_exp_q.push_back(t + 20);
    wait_cyc(t + 3);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    wait_cyc(t + 20);

    // Request held through SETTLE is taken on the done cycle; reset mid-ramp.
    issue(32'h0000_1000, 1'b0, 1'b0, t);
    expect_span(t + 1, t + 16, 32'h0000_1000, 1'b1, 1'b0, "held_jump_settle");
    expect_at(t + 17, 32'h0000_1000, 1'b0, 1'b1, "held_done_cycle");
    done_exp_q.push_back(t + 17);
    issue(32'h0050_0000, 1'b1, 1'b0, t2);
    total++;
    if (t2 != t + 17) begin
      bad++;
      $display("FAIL held_accept_cycle: got accept at cyc=%0d, want cyc=%0d", t2, t + 17);
    end
    expect_at(t2 + 1, 32'h0000_1000, 1'b0, 1'b0, "held_ramp_enter");
    expect_at(t2 + 2, 32'h0010_1000, 1'b0, 1'b0, "held_ramp_s1");
    expect_at(t2 + 3, 32'h0020_1000, 1'b0, 1'b0, "held_ramp_s2");
    wait_cyc(t2 + 4);
    rst_n = 1'b0;
    expect_at(cyc, 32'h0, 1'b1, 1'b0, "reset_mid_ramp");
    @(posedge clk); #1;
    expect_at(cyc, 32'h0, 1'b1, 1'b0, "reset_mid_ramp_hold");
    @(posedge clk); #1;
    rst_n = 1'b1; r = cyc;
    expect_span(r, r + 15, 32'h0, 1'b1, 1'b0, "reset2_settle");
    expect_at(r + 16, 32'h0, 1'b0, 1'b1, "reset2_done");
    done_exp_q.push_back(r + 16);
    wait_cyc(r + 18);

    for (int n = 0; n < 50; n++) begin
      if (chk_q.size() == 0 && done_exp_q.size() == 0) break;
      @(posedge clk); #1;
    end
    if (chk_q.size() != 0 || done_exp_q.size() != 0) begin
      total++; bad++;
      $display("FAIL drain: got %0d checks and %0d dones pending, want 0",
               chk_q.size(), done_exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mixer_tune_ctrl.md
Name: mixer_tune_ctrl

Overview:
Retuning controller for the quadrature mixer datapath. It accepts frequency-change requests through a valid/ready handshake and drives the phase increment of the NCO that feeds the mixer's sine/cosine inputs. A request is applied either as an immediate jump, with the mixer outputs muted while the downstream filter settles, or as a phase-continuous ramp. A one-cycle done pulse marks the point where the new frequency is valid downstream.

Parameters:
PHASE_WIDTH, 32, width of the NCO phase increment word.
RAMP_STEP, 32'h0010_0000, maximum change of phase_inc per clock in ramp mode (unsigned, nonzero).
SETTLE_CYCLES, 16, cycles counted after the final phase_inc update before done (covers mixer plus decimator pipeline latency); minimum 1.
RESET_INC, 0, phase_inc value on reset.

Ports:
clk  input  1  system clock, all logic on rising edge.
rst_n  input  1  asynchronous active-low reset.
tune_valid  input  1  request valid; must hold tune_word/tune_ramp stable until accepted.
tune_ready  output  1  controller can accept a request.
tune_word  input  PHASE_WIDTH  target phase increment (unsigned).
tune_ramp  input  1  1 = ramp to target, 0 = jump.
abort  input  1  terminates an in-progress ramp.
phase_inc  output  PHASE_WIDTH  phase increment to the NCO (registered).
mute  output  1  1 = mixer output must be forced to zero.
busy  output  1  high in RAMP or SETTLE.
done  output  1  one-cycle pulse when a retune completes.

Behaviour:
- States: IDLE, RAMP, SETTLE. Settle counter is $clog2(SETTLE_CYCLES+1) bits wide.
- Reset (async, rst_n=0):
  - state=SETTLE, counter=SETTLE_CYCLES.
  - phase_inc=RESET_INC, mute=1, tune_ready=0, busy=1, done=0.
  - After release, the controller completes this settle normally: done pulses, then state goes to IDLE. This reset settle is treated as a jump-type settle.
- tune_ready = (state==IDLE). busy = !tune_ready. All outputs are registered.
- IDLE, on handshake (tune_valid & tune_ready), with the target latched that cycle:
  - tune_word == phase_inc: no change, no settle. done=1 next cycle, stay IDLE, mute stays 0.
  - tune_ramp=0, or |tune_word-phase_inc| <= RAMP_STEP: phase_inc<=tune_word next cycle, go to SETTLE with counter=SETTLE_CYCLES. mute=1 only when tune_ramp=0.
  - Otherwise go to RAMP.
- RAMP:
  - Each cycle, if the remaining distance is greater than RAMP_STEP, phase_inc moves RAMP_STEP toward the target. Direction is by unsigned compare; no modulo wrap is taken.
  - Otherwise phase_inc<=target and go to SETTLE with mute=0.
  - abort=1: phase_inc holds its current value, go to SETTLE with mute=0; done still pulses at the end.
  - mute is 0 throughout RAMP.
- SETTLE:
  - Counter decrements by 1 each cycle. When it reaches 1, the next cycle has state=IDLE, done=1, mute=0.
  - Latency from jump acceptance to done is SETTLE_CYCLES+1 cycles.
  - abort is ignored. tune_valid is not accepted (tune_ready=0); the requester holds it, and it is accepted on the first IDLE cycle, which can coincide with the done pulse.
- Simultaneous tune_valid and abort in IDLE: abort is ignored and the request is accepted.
- Reset asserted mid-RAMP or mid-SETTLE: the controller returns immediately to the reset state above, the latched target is discarded, and no done pulse occurs for the aborted request.
- Arithmetic: the distance is computed at PHASE_WIDTH+1 bits to avoid overflow near 0 and 2^PHASE_WIDTH-1. Step updates never overshoot the target.

Test Plan:
1. Reset release, RESET_INC=0 -> mute=1, tune_ready=0 for 16 cycles; done pulses on cycle 17; then mute=0, tune_ready=1.
2. Jump: tune_word=32'h0800_0000, tune_ramp=0 accepted at cycle T -> phase_inc=32'h0800_0000 at T+1; mute=1 from T+1 through T+16; done=1 at T+17.
3. Ramp up from 0 to 32'h0035_0000 -> phase_inc goes 0x0010_0000, 0x0020_0000, 0x0030_0000, then 0x0035_0000; mute never asserted; done 16 cycles after the final value.
4. Ramp down from 32'h0035_0000 to 32'h0000_0001, with abort pulsed after 2 steps -> phase_inc freezes at 32'h0015_0000; SETTLE 16 cycles; done=1.
5. tune_word equal to the current phase_inc -> tune_ready stays 1; done pulses the next cycle; mute stays 0; phase_inc unchanged.
6. tune_valid held during SETTLE; rst_n pulsed low mid-RAMP -> request accepted on the done cycle; on reset, phase_inc returns to RESET_INC, mute=1, no done for the aborted ramp.
